// File: rtl/id_ex_stage_pkg.sv
// Shared types for the ID/EX skid stage: FSM states, funct3 codes, entry record
// and the write-back bypass patch helper.
package id_ex_stage_pkg;

  localparam int ENTRY_DATA_W = 32;
  localparam int ENTRY_REG_W  = 5;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } skidState_t;

  localparam logic [2:0] FUNCT3_ADD = 3'b000;
  localparam logic [2:0] FUNCT3_SR  = 3'b101;

  typedef struct packed {
    logic [ENTRY_DATA_W-1:0] dataA;
    logic [ENTRY_DATA_W-1:0] dataB;
    logic [2:0]              funct3;
    logic [6:0]              funct7;
    logic [ENTRY_REG_W-1:0]  rd;
    logic [ENTRY_REG_W-1:0]  rs1;
    logic [ENTRY_REG_W-1:0]  rs2;
    logic                    regWrite;
  } entry_t;

  // rs2 is stored as zero for immediate ops, so operand B is never bypassed there
  function automatic entry_t fwdPatch(input entry_t e,
                                      input logic fwdValid,
                                      input logic [ENTRY_REG_W-1:0] fwdRd,
                                      input logic [ENTRY_DATA_W-1:0] fwdData);
    entry_t r;
    r = e;
    if (fwdValid && (fwdRd != '0) && (fwdRd == e.rs1)) r.dataA = fwdData;
    if (fwdValid && (fwdRd != '0) && (fwdRd == e.rs2)) r.dataB = fwdData;
    return r;
  endfunction

endpackage

// File: rtl/id_ex_stage_operand_sel.sv
// Builds the ID/EX entry from decode fields: immediate select, funct7/rd masking,
// and optional write-back bypass when ID_EX_FORWARDING_EN is defined.
module id_ex_operand_sel
  import id_ex_stage_pkg::*;
#(
  parameter int REG_ADDR_W = 5,
  parameter int DATA_W     = 32
) (
  input  logic [DATA_W-1:0]     rs1Data,
  input  logic [DATA_W-1:0]     rs2Data,
  input  logic [DATA_W-1:0]     imm,
  input  logic                  useImm,
  input  logic [2:0]            funct3,
  input  logic [6:0]            funct7,
  input  logic [REG_ADDR_W-1:0] rs1,
  input  logic [REG_ADDR_W-1:0] rs2,
  input  logic [REG_ADDR_W-1:0] rd,
  input  logic                  regWrite,
`ifdef ID_EX_FORWARDING_EN
  input  logic                  fwdValid,
  input  logic [REG_ADDR_W-1:0] fwdRd,
  input  logic [DATA_W-1:0]     fwdData,
`endif
  output entry_t                captured
);

  // Shift-right keeps funct7 so SRAI survives; other immediates must never look like SUB
  always_comb begin
    captured          = '0;
    captured.dataA    = rs1Data;
    captured.dataB    = useImm ? imm : rs2Data;
    captured.funct3   = funct3;
    captured.funct7   = (useImm && (funct3 != FUNCT3_SR)) ? 7'b0 : funct7;
    captured.rd       = rd;
    captured.rs1      = rs1;
    captured.rs2      = useImm ? '0 : rs2;
    captured.regWrite = regWrite && (rd != '0);
`ifdef ID_EX_FORWARDING_EN
    captured = fwdPatch(captured, fwdValid, fwdRd, fwdData);
`endif
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register as a two-entry skid buffer (EMPTY/ONE/TWO).
// Define ID_EX_FORWARDING_EN to add the iFwd* write-back bypass ports.
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int REG_ADDR_W = 5,
  parameter int DATA_W     = 32
) (
  input  logic                  iClk,
  input  logic                  iRstN,
  input  logic                  iValid,
  output logic                  oReady,
  input  logic [DATA_W-1:0]     iRs1Data,
  input  logic [DATA_W-1:0]     iRs2Data,
  input  logic [DATA_W-1:0]     iImm,
  input  logic                  iUseImm,
  input  logic [2:0]            iFunct3,
  input  logic [6:0]            iFunct7,
  input  logic [REG_ADDR_W-1:0] iRs1,
  input  logic [REG_ADDR_W-1:0] iRs2,
  input  logic [REG_ADDR_W-1:0] iRd,
  input  logic                  iRegWrite,
  input  logic                  iFlush,
`ifdef ID_EX_FORWARDING_EN
  input  logic                  iFwdValid,
  input  logic [REG_ADDR_W-1:0] iFwdRd,
  input  logic [DATA_W-1:0]     iFwdData,
`endif
  output logic                  oValid,
  input  logic                  iReady,
  output logic [DATA_W-1:0]     oDataA,
  output logic [DATA_W-1:0]     oDataB,
  output logic [2:0]            oFunct3,
  output logic [6:0]            oFunct7,
  output logic [REG_ADDR_W-1:0] oRd,
  output logic                  oRegWrite
);

  skidState_t state, nextState;
  entry_t     mainEntry, skidEntry, mainNext, skidNext;
  entry_t     mainHeld, skidHeld, captured;
  logic       readyReg, inXfer, outXfer;

  id_ex_operand_sel #(.REG_ADDR_W(REG_ADDR_W), .DATA_W(DATA_W)) operandSel (
    .rs1Data  (iRs1Data),
    .rs2Data  (iRs2Data),
    .imm      (iImm),
    .useImm   (iUseImm),
    .funct3   (iFunct3),
    .funct7   (iFunct7),
    .rs1      (iRs1),
    .rs2      (iRs2),
    .rd       (iRd),
    .regWrite (iRegWrite),
`ifdef ID_EX_FORWARDING_EN
    .fwdValid (iFwdValid),
    .fwdRd    (iFwdRd),
    .fwdData  (iFwdData),
`endif
    .captured (captured)
  );

`ifdef ID_EX_FORWARDING_EN
  assign mainHeld = fwdPatch(mainEntry, iFwdValid, iFwdRd, iFwdData);
  assign skidHeld = fwdPatch(skidEntry, iFwdValid, iFwdRd, iFwdData);
`else
  assign mainHeld = mainEntry;
  assign skidHeld = skidEntry;
`endif

  assign oReady  = readyReg;
  assign oValid  = (state != EMPTY);
  assign inXfer  = iValid && readyReg;
  assign outXfer = oValid && iReady;

  always_ff @(posedge iClk) begin
    if (!iRstN) begin
      state     <= EMPTY;
      readyReg  <= 1'b1;
      mainEntry <= '0;
      skidEntry <= '0;
    end else begin
      state     <= nextState;
      readyReg  <= (nextState != TWO);
      mainEntry <= mainNext;
      skidEntry <= skidNext;
    end
  end

  // Flush wins over every handshake and leaves the visible fields untouched
  always_comb begin
    nextState = state;
    mainNext  = mainEntry;
    skidNext  = skidEntry;
    if (!iFlush) begin
      unique case (state)
        EMPTY: begin
          if (inXfer) begin
            nextState = ONE;
            mainNext  = captured;
          end
        end
        ONE: begin
          mainNext = mainHeld;
          if (inXfer && outXfer) begin
            mainNext = captured;
          end else if (inXfer) begin
            nextState = TWO;
            skidNext  = captured;
          end else if (outXfer) begin
            nextState = EMPTY;
          end
        end
        TWO: begin
          mainNext = mainHeld;
          skidNext = skidHeld;
          if (outXfer) begin
            nextState = ONE;
            mainNext  = skidHeld;
          end
        end
        default: nextState = EMPTY;
      endcase
    end else begin
      nextState = EMPTY;
    end
  end

  assign oDataA    = mainEntry.dataA;
  assign oDataB    = mainEntry.dataB;
  assign oFunct3   = mainEntry.funct3;
  assign oFunct7   = mainEntry.funct7;
  assign oRd       = mainEntry.rd;
  assign oRegWrite = mainEntry.regWrite;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed self-checking bench for id_ex_stage; bypass vectors run only when
// ID_EX_FORWARDING_EN is defined.
module tb_id_ex_stage;
  import id_ex_stage_pkg::*;

  logic        iClk = 1'b0;
  logic        iRstN = 1'b0;
  logic        iValid = 1'b0, oReady;
  logic [31:0] iRs1Data = '0, iRs2Data = '0, iImm = '0;
  logic        iUseImm = 1'b0;
  logic [2:0]  iFunct3 = '0;
  logic [6:0]  iFunct7 = '0;
  logic [4:0]  iRs1 = '0, iRs2 = '0, iRd = '0;
  logic        iRegWrite = 1'b0, iFlush = 1'b0;
  logic        oValid, iReady = 1'b0;
  logic [31:0] oDataA, oDataB;
  logic [2:0]  oFunct3;
  logic [6:0]  oFunct7;
  logic [4:0]  oRd;
  logic        oRegWrite;
`ifdef ID_EX_FORWARDING_EN
  logic        iFwdValid = 1'b0;
  logic [4:0]  iFwdRd = '0;
  logic [31:0] iFwdData = '0;
`endif

  int total = 0;
  int bad = 0;

  id_ex_stage dut (
    .iClk(iClk), .iRstN(iRstN), .iValid(iValid), .oReady(oReady),
    .iRs1Data(iRs1Data), .iRs2Data(iRs2Data), .iImm(iImm), .iUseImm(iUseImm),
    .iFunct3(iFunct3), .iFunct7(iFunct7), .iRs1(iRs1), .iRs2(iRs2), .iRd(iRd),
    .iRegWrite(iRegWrite), .iFlush(iFlush),
`ifdef ID_EX_FORWARDING_EN
    .iFwdValid(iFwdValid), .iFwdRd(iFwdRd), .iFwdData(iFwdData),
`endif
    .oValid(oValid), .iReady(iReady), .oDataA(oDataA), .oDataB(oDataB),
    .oFunct3(oFunct3), .oFunct7(oFunct7), .oRd(oRd), .oRegWrite(oRegWrite)
  );

  always #5 iClk = ~iClk;

  task automatic tick();
    @(posedge iClk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic valid, input logic [31:0] a,
                               input logic [31:0] b, input logic [31:0] imm,
                               input logic useImm, input logic [2:0] f3,
                               input logic [6:0] f7, input logic [4:0] rd,
                               input logic rw);
    iValid    = valid;
    iRs1Data  = a;
    iRs2Data  = b;
    iImm      = imm;
    iUseImm   = useImm;
    iFunct3   = f3;
    iFunct7   = f7;
    iRd       = rd;
    iRegWrite = rw;
  endtask

  initial begin
    // reset state
    tick();
    tick();
    checkOutput("rstValid", {31'b0, oValid}, 32'd0);
    checkOutput("rstReady", {31'b0, oReady}, 32'd1);
    checkOutput("rstDataA", oDataA, 32'd0);
    checkOutput("rstDataB", oDataB, 32'd0);
    checkOutput("rstFunct7", {25'b0, oFunct7}, 32'd0);
    checkOutput("rstRd", {27'b0, oRd}, 32'd0);
    iRstN = 1'b1;

    // basic register-register capture with one-cycle latency
    iReady = 1'b1;
    applyStimulus(1'b1, 32'd5, 32'd7, 32'd0, 1'b0, FUNCT3_ADD, 7'h00, 5'd1, 1'b1);
    tick();
    checkOutput("basicValid", {31'b0, oValid}, 32'd1);
    checkOutput("basicDataA", oDataA, 32'd5);
    checkOutput("basicDataB", oDataB, 32'd7);
    checkOutput("basicRd", {27'b0, oRd}, 32'd1);
    checkOutput("basicRegWrite", {31'b0, oRegWrite}, 32'd1);
    iValid = 1'b0;
    tick();
    checkOutput("drainValid", {31'b0, oValid}, 32'd0);

    // immediate select and funct7 masking (ADDI vs SRAI)
    applyStimulus(1'b1, 32'd9, 32'd3, 32'hFFFF_FFFF, 1'b1, FUNCT3_ADD, 7'h20, 5'd2, 1'b1);
    tick();
    checkOutput("immDataB", oDataB, 32'hFFFF_FFFF);
    checkOutput("addiFunct7", {25'b0, oFunct7}, 32'd0);
    applyStimulus(1'b1, 32'd9, 32'd3, 32'hFFFF_FFFF, 1'b1, FUNCT3_SR, 7'h20, 5'd2, 1'b1);
    tick();
    checkOutput("sraiFunct7", {25'b0, oFunct7}, 32'h20);
    checkOutput("sraiFunct3", {29'b0, oFunct3}, 32'd5);
    iValid = 1'b0;
    tick();

    // rd zero masks regWrite, then reset while an entry is held
    applyStimulus(1'b1, 32'd4, 32'd6, 32'd0, 1'b0, FUNCT3_ADD, 7'h00, 5'd0, 1'b1);
    tick();
    checkOutput("rdZeroRegWrite", {31'b0, oRegWrite}, 32'd0);
    iValid = 1'b0;
    iReady = 1'b0;
    tick();
    checkOutput("holdValid", {31'b0, oValid}, 32'd1);
    checkOutput("holdDataA", oDataA, 32'd4);
    iRstN = 1'b0;
    tick();
    checkOutput("midRstValid", {31'b0, oValid}, 32'd0);
    checkOutput("midRstDataA", oDataA, 32'd0);
    checkOutput("midRstDataB", oDataB, 32'd0);
    checkOutput("midRstReady", {31'b0, oReady}, 32'd1);
    iRstN = 1'b1;

    // backpressure: three offered, two accepted, order preserved
    applyStimulus(1'b1, 32'd11, 32'd0, 32'd0, 1'b0, FUNCT3_ADD, 7'h00, 5'd3, 1'b1);
    tick();
    checkOutput("bpReady1", {31'b0, oReady}, 32'd1);
    iRs1Data = 32'd12;
    tick();
    checkOutput("bpReady2", {31'b0, oReady}, 32'd0);
    iRs1Data = 32'd13;
    tick();
    checkOutput("bpReady3", {31'b0, oReady}, 32'd0);
    checkOutput("bpStable", oDataA, 32'd11);
    iValid = 1'b0;
    iReady = 1'b1;
    tick();
    checkOutput("bpSecond", oDataA, 32'd12);
    checkOutput("bpReadyBack", {31'b0, oReady}, 32'd1);
    tick();
    checkOutput("bpNoThird", {31'b0, oValid}, 32'd0);

    // flush from TWO drops everything, including the same-cycle input
    iReady = 1'b0;
    applyStimulus(1'b1, 32'd21, 32'd0, 32'd0, 1'b0, FUNCT3_ADD, 7'h00, 5'd4, 1'b1);
    tick();
    iRs1Data = 32'd22;
    tick();
    iRs1Data = 32'd23;
    iFlush = 1'b1;
    tick();
    checkOutput("flushValid", {31'b0, oValid}, 32'd0);
    checkOutput("flushReady", {31'b0, oReady}, 32'd1);
    checkOutput("flushFields", oDataA, 32'd21);
    iFlush = 1'b0;
    iValid = 1'b0;
    iReady = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("flushNoEmerge", {31'b0, oValid}, 32'd0);
    end

`ifdef ID_EX_FORWARDING_EN
    // write-back bypass onto operand A, and rd zero never bypasses
    iRs1 = 5'd3;
    iFwdValid = 1'b1;
    iFwdRd = 5'd3;
    iFwdData = 32'hAA;
    applyStimulus(1'b1, 32'd1, 32'd2, 32'd0, 1'b0, FUNCT3_ADD, 7'h00, 5'd5, 1'b1);
    tick();
    checkOutput("fwdDataA", oDataA, 32'hAA);
    iRs1 = 5'd0;
    iFwdRd = 5'd0;
    tick();
    checkOutput("fwdZeroDataA", oDataA, 32'd1);
    iValid = 1'b0;
    iFwdValid = 1'b0;
    tick();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
